flit_pattern_injector: RTL and testbench
========================================

# flit_pattern_injector

- Synthesizable, packetized stimulus source that sits directly upstream of the `adder` under characterization.
- Generates a deterministic pseudo-random 2N-bit flit stream and splits each flit into the two N-bit adder operands.
- Paces flits into packets of PAYLOAD flits separated by GAP idle cycles, so operand toggle activity and link utilization are set by hardware.
- Replaces testbench-driven injection for on-FPGA and gate-level energy runs.

## Interface
- N, 13, operand width; flit width W = 2N
- PAYLOAD, 20, flits per packet (≥1)
- GAP, 7, idle cycles between packets (≥0)
- NUM_PKT, 10, packets per run (≥1)
- SEED, 1, LFSR seed (W bits); 0 is replaced by 1
- TAPS, 26'h2000023, Galois feedback mask (W bits)
- clk  in  1  single clock; all logic on rising edge
- rst_n  in  1  reset, synchronous and active-low
- start  in  1  one-cycle request to begin a run
- busy  out  1  run in progress
- done  out  1  one-cycle pulse after the last flit of the last packet is accepted
- out_valid  out  1  operands valid
- out_ready  in  1  consumer accepts when out_valid & out_ready
- input1  out  N  operand 1 = flit[N-1:0]
- input2  out  N  operand 2 = flit[2N-1:N]
- out_sof  out  1  first flit of packet
- out_eof  out  1  last flit of packet

## Operation
- States: IDLE, SEND, GAP, DONE.
- IDLE:
  - start=1 → load lfsr = step(SEED), clear flit/packet counters, go to SEND.
  - start is ignored in every other state.
- SEND:
  - out_valid=1; flit = lfsr.
  - On accept: lfsr = step(lfsr), flit_idx++.
  - When the accepted flit is flit_idx==PAYLOAD-1:
    - pkt_idx++.
    - If pkt_idx==NUM_PKT-1 → DONE.
    - Else if GAP==0 → stay in SEND with the next packet.
    - Else → GAP with gap_cnt=GAP-1.
- GAP: out_valid=0; decrement gap_cnt; at 0 → SEND.
- DONE: done=1 for one cycle → IDLE.
- step(s): if s[0] then (s>>1)^TAPS else s>>1. All counters and the LFSR are unsigned W-bit values with no wrap inside a run.
- The LFSR continues across packets within a run and is reseeded on every start.
- Stall: while out_valid & !out_ready, input1, input2, out_sof and out_eof are held stable and the LFSR does not advance.
- out_sof = (flit_idx==0) & out_valid; out_eof = (flit_idx==PAYLOAD-1) & out_valid. PAYLOAD=1 → both high on the same flit.
- busy = 1 in SEND and GAP, 0 in IDLE and DONE.

## Timing
- Reset values: out_valid=0, input1=0, input2=0, out_sof=0, out_eof=0, busy=0, done=0, state=IDLE, lfsr=SEED.
- start sampled at edge k → out_valid=1 with the first flit at cycle k+1.
- The consumer may assert out_ready at any time.
- With out_ready tied high:
  - one flit per cycle within a packet;
  - the last flit of packet p is at cycle t → first flit of packet p+1 at t+GAP+1;
  - done is high one cycle after the final accept.
- Outputs are registered; no combinational path from out_ready to out_valid.
- rst_n low at any edge, including mid-packet or mid-gap, aborts the run and returns to reset values on that edge. done is not pulsed.

## Configuration
- INJ_STATS_EN defined:
  - Adds outputs stat_flits (32 bits, accepted flits) and stat_stalls (32 bits, cycles with out_valid & !out_ready).
  - Both are cleared by reset and by start, and saturate at 2^32-1.
- INJ_STATS_EN undefined: neither port nor its counters exist; behaviour is otherwise identical.

## Structure
- Package `inj_pkg`:
  - state enum (IDLE/SEND/GAP/DONE);
  - default TAPS constant for W=26;
  - lfsr_step function.
- One sub-module `inj_lfsr` (W, SEED, TAPS; load, advance, state out). The FSM and counters stay in the top.

## Test plan
- Defaults, out_ready=1, single start → flits 1..3 are 0x2000023, 0x3000032, 0x1800019; flit 1 gives input1=0x0023, input2=0x1000; flit 2 gives input1=0x0032, input2=0x1800.
- Defaults, out_ready=1 → 200 accepted flits; 7 idle cycles between packets; sof/eof on flits 0 and 19 of each packet; done exactly once, one cycle after the final accept.
- out_ready deasserted for 3 cycles mid-packet → operands, sof and eof are unchanged during the stall; the sequence resumes with no skipped or repeated value; stat_flits=200 and stat_stalls=3 (INJ_STATS_EN).
- GAP=0, PAYLOAD=1, NUM_PKT=4 → 4 back-to-back flits, each with sof=eof=1; busy high for 4 cycles.
- rst_n low during a GAP → outputs at reset values next cycle; the following start restarts at 0x2000023.
- start pulsed while busy → ignored; flit count and sequence are unchanged; SEED=0 → behaves as SEED=1.

Source files
------------

// File: rtl/inj_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : inj_pkg
//  Description : Shared types, constants and the Galois LFSR step used by
//                the flit pattern injector.
//  Revision    : 1.0 - initial release
// ============================================================================
package inj_pkg;

  // Run-control states of the injector
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SEND = 2'd1,
    S_GAP  = 2'd2,
    S_DONE = 2'd3
  } inj_state_e;

  // Widest LFSR the step helper supports; narrower states are zero-extended
  localparam int c_max_w = 64;

  // Feedback mask for the default 26-bit flit (N = 13)
  localparam logic [25:0] c_default_taps = 26'h2000023;

  // One Galois step: shift right, fold the taps in when bit 0 falls out
  function automatic logic [c_max_w-1:0] lfsr_step(input logic [c_max_w-1:0] s,
                                                   input logic [c_max_w-1:0] taps);
    lfsr_step = s[0] ? ((s >> 1) ^ taps) : (s >> 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/inj_lfsr.sv
`default_nettype none
// ============================================================================
//  Module      : inj_lfsr
//  Description : W-bit Galois LFSR. load reseeds to step(SEED), advance takes
//                one step. state_nxt is the value the register takes on the
//                coming edge, so the owner can register a copy in lockstep.
//                A zero SEED is replaced by 1 (all-zero state is a lock-up).
//  Revision    : 1.0 - initial release
// ============================================================================
module inj_lfsr import inj_pkg::*; #(
  parameter int           W    = 26,
  parameter logic [W-1:0] SEED = W'(1),
  parameter logic [W-1:0] TAPS = W'(c_default_taps)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic         advance,
  output logic [W-1:0] state_nxt
);

  localparam logic [W-1:0] c_seed = (SEED == '0) ? W'(1) : SEED;

  logic [W-1:0] lfsr_q, lfsr_d;

  function automatic logic [W-1:0] step_w(input logic [W-1:0] s);
    return W'(lfsr_step(c_max_w'(s), c_max_w'(TAPS)));
  endfunction

  // Next LFSR value: reseed has priority over stepping
  always_comb begin
    lfsr_d = lfsr_q;
    if (load) begin
      lfsr_d = step_w(c_seed);
    end else if (advance) begin
      lfsr_d = step_w(lfsr_q);
    end
  end

  // LFSR state register
  always_ff @(posedge clk) begin
    if (!rst_n) lfsr_q <= c_seed;
    else        lfsr_q <= lfsr_d;
  end

  assign state_nxt = lfsr_d;

endmodule
`default_nettype wire

// File: rtl/flit_pattern_injector.sv
`default_nettype none
// ============================================================================
//  Module      : flit_pattern_injector
//  Description : Packetized pseudo-random operand source for the adder.
//                Emits NUM_PKT packets of PAYLOAD flits separated by GAP idle
//                cycles; each 2N-bit flit is split into input1 (low half) and
//                input2 (high half). All outputs are registered.
//                Optional: define INJ_STATS_EN to add stat_flits/stat_stalls.
//  Revision    : 1.0 - initial release
// ============================================================================
module flit_pattern_injector import inj_pkg::*; #(
  parameter int             N       = 13,
  parameter int             PAYLOAD = 20,
  parameter int             GAP     = 7,
  parameter int             NUM_PKT = 10,
  parameter logic [2*N-1:0] SEED    = (2*N)'(1),
  parameter logic [2*N-1:0] TAPS    = (2*N)'(c_default_taps)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  output logic         busy,
  output logic         done,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] input1,
  output logic [N-1:0] input2,
  output logic         out_sof,
  output logic         out_eof
`ifdef INJ_STATS_EN
  ,
  output logic [31:0]  stat_flits,
  output logic [31:0]  stat_stalls
`endif
);

  localparam int           W           = 2 * N;
  localparam logic [W-1:0] c_one       = W'(1);
  localparam logic [W-1:0] c_last_flit = W'(PAYLOAD - 1);
  localparam logic [W-1:0] c_last_pkt  = W'(NUM_PKT - 1);
  localparam logic [W-1:0] c_gap_init  = W'(GAP - 1);

  inj_state_e   state_q, state_d;
  logic [W-1:0] flit_idx_q, flit_idx_d;
  logic [W-1:0] pkt_idx_q, pkt_idx_d;
  logic [W-1:0] gap_cnt_q, gap_cnt_d;
  logic [W-1:0] flit_q, flit_d;
  logic         out_valid_q, out_valid_d;
  logic         sof_q, sof_d;
  logic         eof_q, eof_d;
  logic         done_q, done_d;
  logic         busy_q, busy_d;
  logic         lfsr_load, lfsr_adv;
  logic [W-1:0] lfsr_nxt;
  logic         w_accept;

  assign w_accept = out_valid_q & out_ready;

  inj_lfsr #(
    .W    (W),
    .SEED (SEED),
    .TAPS (TAPS)
  ) u_lfsr (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (lfsr_load),
    .advance   (lfsr_adv),
    .state_nxt (lfsr_nxt)
  );

  // Run sequencing: next state, counters and next registered outputs
  always_comb begin
    state_d     = state_q;
    flit_idx_d  = flit_idx_q;
    pkt_idx_d   = pkt_idx_q;
    gap_cnt_d   = gap_cnt_q;
    out_valid_d = out_valid_q;
    done_d      = 1'b0;
    lfsr_load   = 1'b0;
    lfsr_adv    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          lfsr_load   = 1'b1;
          flit_idx_d  = '0;
          pkt_idx_d   = '0;
          out_valid_d = 1'b1;
          state_d     = S_SEND;
        end
      end
      S_SEND: begin
        if (w_accept) begin
          lfsr_adv = 1'b1;
          if (flit_idx_q == c_last_flit) begin
            flit_idx_d = '0;
            if (pkt_idx_q == c_last_pkt) begin
              out_valid_d = 1'b0;
              done_d      = 1'b1;
              state_d     = S_DONE;
            end else begin
              pkt_idx_d = pkt_idx_q + c_one;
              if (GAP != 0) begin
                out_valid_d = 1'b0;
                gap_cnt_d   = c_gap_init;
                state_d     = S_GAP;
              end
            end
          end else begin
            flit_idx_d = flit_idx_q + c_one;
          end
        end
      end
      S_GAP: begin
        if (gap_cnt_q == '0) begin
          out_valid_d = 1'b1;
          state_d     = S_SEND;
        end else begin
          gap_cnt_d = gap_cnt_q - c_one;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    // The flit copy tracks the LFSR only when it moves, so it reads 0 after reset
    flit_d = (lfsr_load | lfsr_adv) ? lfsr_nxt : flit_q;
    sof_d  = out_valid_d & (flit_idx_d == '0);
    eof_d  = out_valid_d & (flit_idx_d == c_last_flit);
    busy_d = (state_d == S_SEND) | (state_d == S_GAP);
  end

  // State, counter and output registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      flit_idx_q  <= '0;
      pkt_idx_q   <= '0;
      gap_cnt_q   <= '0;
      flit_q      <= '0;
      out_valid_q <= 1'b0;
      sof_q       <= 1'b0;
      eof_q       <= 1'b0;
      done_q      <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      flit_idx_q  <= flit_idx_d;
      pkt_idx_q   <= pkt_idx_d;
      gap_cnt_q   <= gap_cnt_d;
      flit_q      <= flit_d;
      out_valid_q <= out_valid_d;
      sof_q       <= sof_d;
      eof_q       <= eof_d;
      done_q      <= done_d;
      busy_q      <= busy_d;
    end
  end

  assign out_valid = out_valid_q;
  assign input1    = flit_q[N-1:0];
  assign input2    = flit_q[W-1:N];
  assign out_sof   = sof_q;
  assign out_eof   = eof_q;
  assign done      = done_q;
  assign busy      = busy_q;

`ifdef INJ_STATS_EN
  logic [31:0] stat_flits_q, stat_flits_d;
  logic [31:0] stat_stalls_q, stat_stalls_d;

  // Accepted-flit and stall-cycle counters, cleared on run start, saturating
  always_comb begin
    stat_flits_d  = stat_flits_q;
    stat_stalls_d = stat_stalls_q;
    if ((state_q == S_IDLE) && start) begin
      stat_flits_d  = '0;
      stat_stalls_d = '0;
    end else begin
      if (w_accept && (stat_flits_q != '1)) begin
        stat_flits_d = stat_flits_q + 32'd1;
      end
      if (out_valid_q && !out_ready && (stat_stalls_q != '1)) begin
        stat_stalls_d = stat_stalls_q + 32'd1;
      end
    end
  end

  // Statistics registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stat_flits_q  <= '0;
      stat_stalls_q <= '0;
    end else begin
      stat_flits_q  <= stat_flits_d;
      stat_stalls_q <= stat_stalls_d;
    end
  end

  assign stat_flits  = stat_flits_q;
  assign stat_stalls = stat_stalls_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_flit_pattern_injector.sv
`default_nettype none
// ============================================================================
//  Module      : tb_flit_pattern_injector
//  Description : Scoreboard bench for flit_pattern_injector. Instance A uses
//                the default configuration, instance B uses PAYLOAD=1, GAP=0,
//                NUM_PKT=4, SEED=0.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_flit_pattern_injector;

  localparam int           N       = 13;
  localparam int           W       = 26;
  localparam int           PAYLOAD = 20;
  localparam int           GAP     = 7;
  localparam int           NUM_PKT = 10;
  localparam logic [W-1:0] TAPS    = 26'h2000023;

  typedef struct packed {
    logic [W-1:0] flit;
    logic         sof;
    logic         eof;
    logic         last;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic         start_a = 1'b0, ready_a = 1'b1;
  logic         busy_a, done_a, valid_a, sof_a, eof_a;
  logic [N-1:0] in1_a, in2_a;
  logic         start_b = 1'b0, ready_b = 1'b1;
  logic         busy_b, done_b, valid_b, sof_b, eof_b;
  logic [N-1:0] in1_b, in2_b;
`ifdef INJ_STATS_EN
  logic [31:0]  sf_a, ss_a, sf_b, ss_b;
`endif

  flit_pattern_injector u_dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .busy(busy_a), .done(done_a),
    .out_valid(valid_a), .out_ready(ready_a), .input1(in1_a), .input2(in2_a),
    .out_sof(sof_a), .out_eof(eof_a)
`ifdef INJ_STATS_EN
    , .stat_flits(sf_a), .stat_stalls(ss_a)
`endif
  );

  flit_pattern_injector #(.PAYLOAD(1), .GAP(0), .NUM_PKT(4), .SEED(26'd0)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .busy(busy_b), .done(done_b),
    .out_valid(valid_b), .out_ready(ready_b), .input1(in1_b), .input2(in2_b),
    .out_sof(sof_b), .out_eof(eof_b)
`ifdef INJ_STATS_EN
    , .stat_flits(sf_b), .stat_stalls(ss_b)
`endif
  );

  exp_t         qa[$];
  logic [W-1:0] qb[$];
  int checks = 0, failures = 0;
  int cyc = 0;
  int acc_a = 0, stalls_a = 0, dones_a = 0;
  int busy_cnt_b = 0, dones_b = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference LFSR step, straight from the shift/xor definition
  function automatic logic [W-1:0] ref_step(input logic [W-1:0] s);
    return (s % 2 == 1) ? ((s / 2) ^ TAPS) : (s / 2);
  endfunction

  // Queue the whole expected run for instance A
  task automatic push_run_a(input logic [W-1:0] seed);
    logic [W-1:0] s;
    exp_t e;
    s = (seed == 0) ? W'(1) : seed;
    for (int p = 0; p < NUM_PKT; p++) begin
      for (int f = 0; f < PAYLOAD; f++) begin
        s = ref_step(s);
        e.flit = s;
        e.sof  = (f == 0);
        e.eof  = (f == PAYLOAD - 1);
        e.last = (p == NUM_PKT - 1) && (f == PAYLOAD - 1);
        qa.push_back(e);
      end
    end
  endtask

  // Monitor A: scoreboard pop on accept, stall hold, gap length, done timing
  logic [W+1:0] held;
  bit           held_v = 0;
  bit           done_pend = 0;
  int           eof_cyc = -1;
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      held_v = 0; done_pend = 0; eof_cyc = -1;
    end else begin
      if (done_pend || done_a) chk("done_a_timing", done_a, done_pend);
      if (done_a) dones_a++;
      done_pend = 0;
      if (valid_a) begin
        if (held_v) chk("stall_hold_a", {sof_a, eof_a, in2_a, in1_a}, held);
        if (sof_a && eof_cyc >= 0) begin
          chk("gap_len_a", cyc - eof_cyc, GAP + 1);
          eof_cyc = -1;
        end
        if (ready_a) begin
          held_v = 0;
          if (qa.size() == 0) begin
            chk("unexpected_flit_a", 1, 0);
          end else begin
            e = qa.pop_front();
            acc_a++;
            chk("flit_a", {in2_a, in1_a}, e.flit);
            chk("sof_eof_a", {sof_a, eof_a}, {e.sof, e.eof});
            if (e.eof) eof_cyc = cyc;
            if (e.last) begin done_pend = 1; eof_cyc = -1; end
          end
        end else begin
          held_v = 1;
          held   = {sof_a, eof_a, in2_a, in1_a};
          stalls_a++;
        end
      end
    end
  end

  // Monitor B: every flit is a whole packet
  always @(negedge clk) begin
    logic [W-1:0] eb;
    if (rst_n) begin
      if (busy_b) busy_cnt_b++;
      if (done_b) dones_b++;
      if (valid_b && ready_b) begin
        if (qb.size() == 0) begin
          chk("unexpected_flit_b", 1, 0);
        end else begin
          eb = qb.pop_front();
          chk("flit_b", {in2_b, in1_b}, eb);
          chk("sof_eof_b", {sof_b, eof_b}, 2'b11);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive out_ready per mode until done_a is seen (bounded).
  // mode 0: always ready, plus a stray start mid-run; 1: random; 2: 3-cycle stall
  task automatic run_a(input int mode);
    bit seen = 0;
    for (int i = 0; i < 4000 && !seen; i++) begin
      tick();
      start_a = (mode == 0) && (i == 50);
      case (mode)
        0:       ready_a = 1'b1;
        1:       ready_a = ($urandom_range(0, 3) != 0);
        default: ready_a = !(i >= 10 && i < 13);
      endcase
      @(negedge clk);
      if (done_a) seen = 1;
    end
    chk("run_a_completed", seen, 1);
    tick();
    ready_a = 1'b1;
    start_a = 1'b0;
  endtask

  task automatic pulse_start_a();
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
  endtask

  task automatic check_reset_a(input string name);
    chk(name, {valid_a, in1_a, in2_a, sof_a, eof_a, busy_a, done_a}, '0);
  endtask

  initial begin
    int acc0, st0, dn0;
    bit found;
    logic [W-1:0] s;

    repeat (3) tick();
    rst_n = 1'b1;
    @(negedge clk);
    check_reset_a("reset_values_a");
    chk("reset_values_b", {valid_b, busy_b, done_b, in1_b, in2_b}, '0);

    // Run 1: always ready, known first flits, stray start while busy
    push_run_a(26'd1);
    acc0 = acc_a; dn0 = dones_a;
    tick();
    pulse_start_a();
    @(negedge clk);
    chk("first_flit", {in2_a, in1_a}, 26'h2000023);
    chk("first_input1", in1_a, 13'h0023);
    chk("first_input2", in2_a, 13'h1000);
    chk("busy_in_send", busy_a, 1);
    @(negedge clk);
    chk("second_input1", in1_a, 13'h0032);
    chk("second_input2", in2_a, 13'h1800);
    @(negedge clk);
    chk("third_flit", {in2_a, in1_a}, 26'h1800019);
    run_a(0);
    chk("run1_accepts", acc_a - acc0, PAYLOAD * NUM_PKT);
    chk("run1_done_once", dones_a - dn0, 1);
    chk("run1_queue_empty", qa.size(), 0);
    chk("run1_idle_busy", busy_a, 0);
`ifdef INJ_STATS_EN
    chk("run1_stat_flits", sf_a, PAYLOAD * NUM_PKT);
    chk("run1_stat_stalls", ss_a, 0);
`endif

    // Run 2: three stall cycles mid-packet
    push_run_a(26'd1);
    acc0 = acc_a; st0 = stalls_a;
    pulse_start_a();
    run_a(2);
    chk("run2_accepts", acc_a - acc0, PAYLOAD * NUM_PKT);
    chk("run2_stalls_seen", stalls_a - st0, 3);
`ifdef INJ_STATS_EN
    chk("run2_stat_flits", sf_a, PAYLOAD * NUM_PKT);
    chk("run2_stat_stalls", ss_a, 3);
`endif

    // Run 3: random backpressure
    push_run_a(26'd1);
    acc0 = acc_a; st0 = stalls_a;
    pulse_start_a();
    run_a(1);
    chk("run3_accepts", acc_a - acc0, PAYLOAD * NUM_PKT);
`ifdef INJ_STATS_EN
    chk("run3_stat_flits", sf_a, PAYLOAD * NUM_PKT);
    chk("run3_stat_stalls", ss_a, stalls_a - st0);
`endif

    // Run 4: reset in the first inter-packet gap, then a clean restart
    push_run_a(26'd1);
    dn0 = dones_a;
    pulse_start_a();
    found = 0;
    for (int i = 0; i < 100 && !found; i++) begin
      @(negedge clk);
      if (valid_a && eof_a && ready_a) found = 1;
      else tick();
    end
    chk("reached_first_eof", found, 1);
    tick();
    tick();
    chk("in_gap_before_reset", {busy_a, valid_a}, 2'b10);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check_reset_a("reset_mid_gap");
    #1;
    qa.delete();
    tick();
    rst_n = 1'b1;
    chk("no_done_on_abort", dones_a - dn0, 0);
    push_run_a(26'd1);
    acc0 = acc_a;
    pulse_start_a();
    @(negedge clk);
    chk("restart_first_flit", {in2_a, in1_a}, 26'h2000023);
    run_a(1);
    chk("restart_accepts", acc_a - acc0, PAYLOAD * NUM_PKT);

    // Instance B: single-flit packets, no gap, SEED=0 behaves as SEED=1
    s = 26'd1;
    for (int k = 0; k < 4; k++) begin
      s = ref_step(s);
      qb.push_back(s);
    end
    busy_cnt_b = 0; dones_b = 0;
    start_b = 1'b1;
    tick();
    start_b = 1'b0;
    found = 0;
    for (int i = 0; i < 50 && !found; i++) begin
      @(negedge clk);
      if (done_b) found = 1;
      else tick();
    end
    chk("b_done_seen", found, 1);
    repeat (3) tick();
    chk("b_busy_cycles", busy_cnt_b, 4);
    chk("b_done_once", dones_b, 1);
    chk("b_queue_empty", qb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
